pulse_sync_multi: RTL

- Multi-channel, parametrised successor to the team's single-pulse cross-domain handshake.
- Lives entirely in the destination clock domain. Each channel takes an asynchronous request (level or toggle) from a foreign domain, synchronizes it, and detects events.
- Events are queued in a per-channel saturating pending counter and presented downstream through valid/ready.
- Returns a synchronized ack level to the source for 4-phase handshaking, and flags lost events.

---
 rtl/pulse_sync_pkg.sv | 8 +
 rtl/pulse_sync_ch.sv | 79 +++++++
 rtl/pulse_sync_multi.sv | 40 ++++
 3 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared constants for the multi-channel pulse synchronizer.
package pulse_sync_pkg;

  localparam int unsigned MODE_LEVEL  = 0;
  localparam int unsigned MODE_TOGGLE = 1;
  localparam int unsigned SYNC_MIN    = 2;

endpackage : pulse_sync_pkg

// File: rtl/pulse_sync_ch.sv
// One channel: request synchronizer, edge detect, saturating pending counter
// and sticky overflow flag, all in the clkout domain.
module pulse_sync_ch
  import pulse_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = MODE_LEVEL,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             clkout,
  input  logic             rstn,
  input  logic             req_async,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             ack,
  output logic             evt_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  // Chains shorter than the minimum are not metastability-safe; clamp up.
  localparam int unsigned     STAGES  = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              valid_q;
  logic              ovf_q;
  logic              ovf_d;
  logic              det;
  logic              pop;

  // State registers; valid is registered from the next count so it tracks cnt != 0.
  always_ff @(posedge clkout or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], req_async};
      dly_q   <= sync_q[STAGES-1];
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      ovf_q   <= ovf_d;
    end
  end

  // Event detect and counter update; a drop sets ovf even when cleared the same cycle.
  always_comb begin
    det   = 1'b0;
    pop   = valid_q & evt_ready;
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~ovf_clr;
    if (MODE == MODE_TOGGLE) begin
      det = sync_q[STAGES-1] ^ dly_q;
    end else begin
      det = sync_q[STAGES-1] & ~dly_q;
    end
    if (det && !pop) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!det && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign ack       = sync_q[STAGES-1];
  assign evt_valid = valid_q;
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;

endmodule : pulse_sync_ch

// File: rtl/pulse_sync_multi.sv
// NCH independent cross-domain request channels with queued events,
// synchronized ack return and sticky per-channel overflow.
module pulse_sync_multi
  import pulse_sync_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = MODE_LEVEL,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                 clkout,
  input  logic                 rstn,
  input  logic [NCH-1:0]       req_async,
  output logic [NCH-1:0]       ack,
  output logic [NCH-1:0]       evt_valid,
  input  logic [NCH-1:0]       evt_ready,
  output logic [NCH*CNT_W-1:0] pend_cnt,
  output logic [NCH-1:0]       ovf,
  input  logic                 ovf_clr
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_sync_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .MODE        (MODE),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clkout    (clkout),
      .rstn      (rstn),
      .req_async (req_async[i]),
      .evt_ready (evt_ready[i]),
      .ovf_clr   (ovf_clr),
      .ack       (ack[i]),
      .evt_valid (evt_valid[i]),
      .cnt       (pend_cnt[i*CNT_W +: CNT_W]),
      .ovf       (ovf[i])
    );
  end

endmodule : pulse_sync_multi
